// File: rtl/riscv_defines.sv
// Shared definitions for the core's custom string unit: operator encodings,
// FSM state type and the ASCII constants used by the byte transforms.
package riscv_defines;

  localparam int STR_OP_WIDTH = 2;

  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 2'd3;

  typedef enum logic [1:0] {
    STR_IDLE = 2'd0,
    STR_BUSY = 2'd1,
    STR_DONE = 2'd2
  } str_state_t;

  localparam logic [7:0] ASCII_UPPER_A    = 8'h41;
  localparam logic [7:0] ASCII_UPPER_M    = 8'h4D;
  localparam logic [7:0] ASCII_UPPER_Z    = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
  localparam logic [7:0] ASCII_LOWER_M    = 8'h6D;
  localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;
  localparam logic [7:0] ROT13_DELTA      = 8'd13;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z);
  endfunction

endpackage

// File: rtl/riscv_str_byte.sv
// Combinational transform of one ASCII byte for the string unit.
// Bytes outside the letter ranges (including all bytes >= 0x80) pass through.
module riscv_str_byte
  import riscv_defines::*;
(
  input  logic [7:0]              src,
  input  logic [STR_OP_WIDTH-1:0] op,
  output logic [7:0]              dst
);

  logic       up;
  logic       lo;
  logic [7:0] folded;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    up     = is_upper(src);
    lo     = is_lower(src);
    folded = src | ASCII_CASE_DELTA;
    dst    = src;
    case (op)
      STR_OP_UPPER: if (lo) dst = src - ASCII_CASE_DELTA;
      STR_OP_LOWER: if (up) dst = src + ASCII_CASE_DELTA;
      STR_OP_LEET: begin
        // Case-insensitive: fold letters to lowercase before matching.
        if (up || lo) begin
          case (folded)
            8'h61:   dst = 8'h34;
            8'h65:   dst = 8'h33;
            8'h69:   dst = 8'h31;
            8'h6F:   dst = 8'h30;
            8'h73:   dst = 8'h35;
            8'h74:   dst = 8'h37;
            default: dst = src;
          endcase
        end
      end
      STR_OP_ROT13: begin
        // First half of the alphabet moves up by 13, second half wraps down by 13.
        if (up)      dst = (src <= ASCII_UPPER_M) ? src + ROT13_DELTA : src - ROT13_DELTA;
        else if (lo) dst = (src <= ASCII_LOWER_M) ? src + ROT13_DELTA : src - ROT13_DELTA;
      end
      default: dst = src;
    endcase
  end

endmodule

// File: rtl/riscv_str_unit.sv
// Multi-cycle EX-stage unit for the custom string ops. Transforms
// BYTES_PER_CYCLE bytes of the latched word per BUSY cycle, then holds the
// result in DONE until writeback takes it.
module riscv_str_unit
  import riscv_defines::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_i,
  input  logic                    flush_i,
  input  logic                    ex_ready_i,
  output logic                    ready_o,
  output logic [31:0]             result_o,
  output logic                    valid_o
);

  localparam int         BPC  = BYTES_PER_CYCLE;
  localparam logic [2:0] STEP = 3'(BPC);

  if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
    $error("riscv_str_unit: BYTES_PER_CYCLE must be 1, 2 or 4");
  end

  str_state_t              state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [STR_OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]             result_q, result_d;
  logic                    accept;
  logic                    last_group;

  logic [1:0] lane_idx [BPC];
  logic [7:0] lane_src [BPC];
  logic [7:0] lane_dst [BPC];

  // Byte groups are aligned to BPC, so cnt + lane never wraps past byte 3.
  always_comb begin
    for (int k = 0; k < BPC; k++) begin
      lane_idx[k] = cnt_q + 2'(k);
      lane_src[k] = result_q[{lane_idx[k], 3'b000} +: 8];
    end
  end

  for (genvar k = 0; k < BPC; k++) begin : g_lane
    riscv_str_byte u_byte (
      .src (lane_src[k]),
      .op  (op_q),
      .dst (lane_dst[k])
    );
  end

  assign last_group = (({1'b0, cnt_q}) + STEP) == 3'd4;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    accept   = 1'b0;
    case (state_q)
      STR_IDLE: accept = enable_i;
      STR_BUSY: begin
        for (int k = 0; k < BPC; k++) begin
          result_d[{lane_idx[k], 3'b000} +: 8] = lane_dst[k];
        end
        cnt_d = cnt_q + STEP[1:0];
        if (last_group) state_d = STR_DONE;
      end
      STR_DONE: begin
        // Handshake completes here; a waiting op starts without an IDLE bubble.
        if (ex_ready_i) begin
          state_d = STR_IDLE;
          accept  = enable_i;
        end
      end
      default: state_d = STR_IDLE;
    endcase

    if (accept && !flush_i) begin
      state_d  = STR_BUSY;
      cnt_d    = '0;
      op_d     = operator_i;
      result_d = operand_i;
    end

    // A kill drops both the in-flight op and any op offered in the same cycle.
    if (flush_i) begin
      state_d = STR_IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= STR_IDLE;
      cnt_q    <= '0;
      op_q     <= STR_OP_UPPER;
      // NOTE: the result register is a plain datapath register, reset so that
      // result_o reads zero after reset rather than stale data.
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    case (state_q)
      STR_IDLE: ready_o = 1'b1;
      STR_DONE: ready_o = ex_ready_i;
      default:  ready_o = 1'b0;
    endcase
  end

  assign valid_o  = (state_q == STR_DONE);
  assign result_o = result_q;

endmodule
